// File: rtl/prim_cmp_pkg.sv
// prim_cmp_pkg: shared node type, merge function and depth helper for the pipelined comparator
package prim_cmp_pkg;
  typedef struct packed {
    logic eq;
    logic lt;
  } cmp_node_t;

  function automatic cmp_node_t cmp_merge(cmp_node_t hi, cmp_node_t lo);
    cmp_node_t r;
    r.eq = hi.eq & lo.eq;
    r.lt = hi.lt | (hi.eq & lo.lt);
    return r;
  endfunction

  function automatic int cmp_lvl(int width);
    return $clog2(width / 4);
  endfunction
endpackage

// File: rtl/prim_cmp_mag_4bit.sv
// prim_cmp_mag_4bit: 4-bit unsigned magnitude compare leaf (a, b in; eq, lt out)
module prim_cmp_mag_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq,
  output logic       lt
);
  assign eq = a == b;
  assign lt = a < b;
endmodule

// File: rtl/prim_cmp_pipe_stage.sv
// prim_cmp_pipe_stage: one valid/ready register slice, W-bit payload, holds data while stalled
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  upstream handshake, in_data payload
//   out_valid/ready downstream handshake, out_data payload (0 after reset)
module prim_cmp_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/prim_cmp_pipe.sv
// prim_cmp_pipe: pipelined signed/unsigned WIDTH-bit magnitude comparator with valid/ready and tag
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_valid/o_ready           input handshake; i_a, i_b operands, i_signed_en mode, i_tag sideband
//   o_valid/i_ready           output handshake; o_lt, o_eq, o_gt one-hot result, o_tag
//   o_min, o_max              only with PRIM_CMP_MINMAX_EN defined
module prim_cmp_pipe
  import prim_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed_en,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_lt,
  output logic             o_eq,
  output logic             o_gt,
  output logic [TAG_W-1:0] o_tag
`ifdef PRIM_CMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] o_min,
  output logic [WIDTH-1:0] o_max
`endif
);
  localparam int N   = WIDTH / 4;
  localparam int LVL = cmp_lvl(WIDTH);
`ifdef PRIM_CMP_MINMAX_EN
  localparam int SW = 1 + 2 * WIDTH + TAG_W;
  localparam int FW = 3 + TAG_W + 2 * WIDTH;
`else
  localparam int SW = 3 + TAG_W;
  localparam int FW = 3 + TAG_W;
`endif

  logic fin_rdy;

  genvar k, j;
  for (k = 0; k < LVL; k++) begin : g_st
    localparam int NO = N >> k;
    cmp_node_t [NO-1:0]  nd_d, nd_q;
    logic [SW-1:0]       sd_d, sd_q;
    logic [SW+2*NO-1:0]  pq;
    logic                vi, rdy, vld, nxt_rdy;
    if (k == 0) begin : g_leaf
      assign vi = i_valid;
`ifdef PRIM_CMP_MINMAX_EN
      assign sd_d = {i_signed_en, i_a, i_b, i_tag};
`else
      assign sd_d = {i_signed_en, i_a[WIDTH-1], i_b[WIDTH-1], i_tag};
`endif
      for (j = 0; j < N; j++) begin : g_n
        prim_cmp_mag_4bit u_mag (
          .a (i_a[4*j +: 4]),
          .b (i_b[4*j +: 4]),
          .eq(nd_d[j].eq),
          .lt(nd_d[j].lt)
        );
      end
    end else begin : g_mrg
      assign vi   = g_st[k-1].vld;
      assign sd_d = g_st[k-1].sd_q;
      for (j = 0; j < NO; j++) begin : g_n
        assign nd_d[j] = cmp_merge(g_st[k-1].nd_q[2*j+1], g_st[k-1].nd_q[2*j]);
      end
    end
    if (k == LVL - 1) begin : g_last
      assign nxt_rdy = fin_rdy;
    end else begin : g_next
      assign nxt_rdy = g_st[k+1].rdy;
    end
    prim_cmp_pipe_stage #(.W(SW + 2 * NO)) u_stage (
      .clk      (i_clk),
      .rst      (i_rst),
      .in_valid (vi),
      .in_ready (rdy),
      .in_data  ({sd_d, nd_d}),
      .out_valid(vld),
      .out_ready(nxt_rdy),
      .out_data (pq)
    );
    assign {sd_q, nd_q} = pq;
  end

  cmp_node_t        root;
  logic [SW-1:0]    fs;
  logic [FW-1:0]    fd, fq;
  logic [TAG_W-1:0] ft;
  logic             sgn, am, bm, f_lt, f_eq;

  assign fs   = g_st[LVL-1].sd_q;
  assign root = cmp_merge(g_st[LVL-1].nd_q[1], g_st[LVL-1].nd_q[0]);
  // differing sign bits decide a signed compare outright: the negative operand is smaller
  assign f_lt = (sgn & (am ^ bm)) ? am : root.lt;
  assign f_eq = root.eq;

`ifdef PRIM_CMP_MINMAX_EN
  logic [WIDTH-1:0] fa, fb;
  assign {sgn, fa, fb, ft} = fs;
  assign am = fa[WIDTH-1];
  assign bm = fb[WIDTH-1];
  assign fd = {f_lt, f_eq, ~f_lt & ~f_eq, ft, f_lt ? fa : fb, f_lt ? fb : fa};
  assign {o_lt, o_eq, o_gt, o_tag, o_min, o_max} = fq;
`else
  assign {sgn, am, bm, ft} = fs;
  assign fd = {f_lt, f_eq, ~f_lt & ~f_eq, ft};
  assign {o_lt, o_eq, o_gt, o_tag} = fq;
`endif

  prim_cmp_pipe_stage #(.W(FW)) u_fin (
    .clk      (i_clk),
    .rst      (i_rst),
    .in_valid (g_st[LVL-1].vld),
    .in_ready (fin_rdy),
    .in_data  (fd),
    .out_valid(o_valid),
    .out_ready(i_ready),
    .out_data (fq)
  );

  assign o_ready = g_st[0].rdy;
endmodule

// File: tb/tb_prim_cmp_pipe.sv
// tb_prim_cmp_pipe: self-checking bench for prim_cmp_pipe against an arithmetic reference model
module tb_prim_cmp_pipe;
  localparam int W  = 32;
  localparam int TW = 4;
  localparam int S  = 4;
`ifdef PRIM_CMP_MINMAX_EN
  localparam int OW = 3 + TW + 2 * W;
`else
  localparam int OW = 3 + TW;
`endif

  logic clk = 0, rst = 1, i_valid = 0, i_signed_en = 0, i_ready = 1;
  logic [W-1:0] i_a = '0, i_b = '0;
  logic [TW-1:0] i_tag = '0;
  logic o_ready, o_valid, o_lt, o_eq, o_gt;
  logic [TW-1:0] o_tag;
`ifdef PRIM_CMP_MINMAX_EN
  logic [W-1:0] o_min, o_max;
`endif

  always #5 clk = ~clk;

  prim_cmp_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_signed_en(i_signed_en), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_lt(o_lt), .o_eq(o_eq), .o_gt(o_gt), .o_tag(o_tag)
`ifdef PRIM_CMP_MINMAX_EN
    , .o_min(o_min), .o_max(o_max)
`endif
  );

  typedef struct {
    logic lt, eq, gt;
    logic [TW-1:0] tag;
    logic [W-1:0] mn, mx;
    int acc;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0, pops = 0;
  bit chk_lat = 0, stalled = 0;
  logic [OW-1:0] snap;

  function automatic logic [OW-1:0] out_vec();
`ifdef PRIM_CMP_MINMAX_EN
    return {o_lt, o_eq, o_gt, o_tag, o_min, o_max};
`else
    return {o_lt, o_eq, o_gt, o_tag};
`endif
  endfunction

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic s, logic [TW-1:0] t);
    exp_t e;
    e.lt  = s ? ($signed(a) < $signed(b)) : (a < b);
    e.eq  = a == b;
    e.gt  = !e.lt && !e.eq;
    e.tag = t;
    e.mn  = e.lt ? a : b;
    e.mx  = e.lt ? b : a;
    e.acc = cyc;
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    checks++;
    if (o_ready !== (i_ready || q.size() < S)) begin
      errors++;
      $display("FAIL o_ready cyc=%0d got=%b exp=%b", cyc, o_ready, i_ready || q.size() < S);
    end
    if (stalled) begin
      checks++;
      if (o_valid !== 1'b1 || out_vec() !== snap) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got=%h/%b exp=%h/1", cyc, out_vec(), o_valid, snap);
      end
    end
    if (o_valid && !rst) begin
      checks++;
      if ({o_lt, o_eq, o_gt} !== 3'b100 && {o_lt, o_eq, o_gt} !== 3'b010 && {o_lt, o_eq, o_gt} !== 3'b001) begin
        errors++;
        $display("FAIL onehot cyc=%0d got=%b%b%b exp=one-hot", cyc, o_lt, o_eq, o_gt);
      end
      if (i_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out cyc=%0d got tag=%0d exp=no output", cyc, o_tag);
        end else begin
          e = q.pop_front();
          pops++;
          if ({o_lt, o_eq, o_gt, o_tag} !== {e.lt, e.eq, e.gt, e.tag}) begin
            errors++;
            $display("FAIL result cyc=%0d got=%b%b%b tag=%0d exp=%b%b%b tag=%0d",
                     cyc, o_lt, o_eq, o_gt, o_tag, e.lt, e.eq, e.gt, e.tag);
          end
`ifdef PRIM_CMP_MINMAX_EN
          checks++;
          if (o_min !== e.mn || o_max !== e.mx) begin
            errors++;
            $display("FAIL minmax cyc=%0d got=%h/%h exp=%h/%h", cyc, o_min, o_max, e.mn, e.mx);
          end
`endif
          if (chk_lat) begin
            checks++;
            if (cyc - e.acc != S) begin
              errors++;
              $display("FAIL latency got=%0d exp=%0d", cyc - e.acc, S);
            end
          end
        end
      end
    end
    stalled = o_valid && !i_ready && !rst;
    snap = out_vec();
    if (rst) q.delete();
    else if (i_valid && o_ready) q.push_back(model(i_a, i_b, i_signed_en, i_tag));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(string name);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || out_vec() !== '0) begin
      errors++;
      $display("FAIL %s got valid=%b ready=%b out=%h exp valid=0 ready=1 out=0", name, o_valid, o_ready, out_vec());
    end
  endtask

  task automatic run_one(logic [W-1:0] a, logic [W-1:0] b, logic s, logic [TW-1:0] t, logic [2:0] r);
    chk_lat = 1;
    i_a = a; i_b = b; i_signed_en = s; i_tag = t; i_valid = 1; i_ready = 1;
    cycle();
    i_valid = 0;
    for (int n = 0; n < 12 && q.size() > 0; n++) cycle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL timeout_one got pending=%0d exp=0", q.size());
      q.delete();
    end
    checks++;
    if ({o_lt, o_eq, o_gt, o_tag} !== {r, t}) begin
      errors++;
      $display("FAIL held_result a=%h b=%h s=%b got=%b%b%b tag=%0d exp=%b tag=%0d", a, b, s, o_lt, o_eq, o_gt, o_tag, r, t);
    end
    chk_lat = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_idle("reset_state");
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    run_one(32'h0000_0001, 32'h8000_0000, 0, 4'd5, 3'b100);
    run_one(32'h0000_0001, 32'h8000_0000, 1, 4'd6, 3'b001);
    run_one(32'hFFFF_FFFF, 32'h0000_0000, 1, 4'd7, 3'b100);
    run_one(32'hFFFF_FFFF, 32'h0000_0000, 0, 4'd8, 3'b001);
    run_one(32'h1234_5678, 32'h1234_5678, 0, 4'd9, 3'b010);
    run_one(32'h1234_5678, 32'h1234_5678, 1, 4'd10, 3'b010);
    run_one(32'h1234_5679, 32'h1234_5678, 0, 4'd11, 3'b001);
    run_one(32'h1234_5679, 32'h1234_5678, 1, 4'd12, 3'b001);
    run_one(32'h8000_0000, 32'h7FFF_FFFF, 1, 4'd13, 3'b100);
    run_one(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 4'd14, 3'b100);
  endtask

`ifdef PRIM_CMP_MINMAX_EN
  task automatic test_minmax();
    run_one(32'hFFFF_FFF0, 32'h0000_0010, 1, 4'd1, 3'b100);
    checks++;
    if (o_min !== 32'hFFFF_FFF0 || o_max !== 32'h0000_0010) begin
      errors++;
      $display("FAIL minmax_signed got=%h/%h exp=fffffff0/00000010", o_min, o_max);
    end
    run_one(32'hFFFF_FFF0, 32'h0000_0010, 0, 4'd2, 3'b001);
    checks++;
    if (o_min !== 32'h0000_0010 || o_max !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL minmax_unsigned got=%h/%h exp=00000010/fffffff0", o_min, o_max);
    end
    run_one(32'hCAFE_0001, 32'hCAFE_0001, 1, 4'd3, 3'b010);
    checks++;
    if (o_min !== 32'hCAFE_0001 || o_max !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL minmax_equal got=%h/%h exp=cafe0001/cafe0001", o_min, o_max);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int sent = 0, start = pops;
    bit full = 0, acc;
    for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
      i_ready = !(c >= 3 && c <= 6);
      i_valid = sent < 8;
      i_a = $urandom; i_b = $urandom; i_signed_en = 1'($urandom); i_tag = TW'(sent);
      acc = i_valid && (i_ready || q.size() < S);
      if (!i_ready && q.size() >= S) full = 1;
      cycle();
      if (acc) sent++;
    end
    i_valid = 0; i_ready = 1;
    checks++;
    if (pops - start != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got=%0d pending=%0d exp=8 pending=0", pops - start, q.size());
    end
    checks++;
    if (!full) begin
      errors++;
      $display("FAIL b2b_fill got full=0 exp full=1");
    end
  endtask

  task automatic test_random();
    int m;
    for (int c = 0; c < 400; c++) begin
      i_valid = $urandom_range(0, 9) < 7;
      i_ready = $urandom_range(0, 9) < 6;
      i_signed_en = 1'($urandom);
      i_tag = TW'($urandom);
      m = $urandom_range(0, 3);
      i_a = $urandom;
      i_b = m == 0 ? W'($urandom) : m == 1 ? i_a : m == 2 ? i_a ^ (W'(1) << $urandom_range(0, W - 1)) : ~i_a;
      cycle();
    end
    i_valid = 0; i_ready = 1;
    for (int n = 0; n < 20 && q.size() > 0; n++) cycle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL random_drain got pending=%0d exp=0", q.size());
      q.delete();
    end
  endtask

  task automatic test_midreset();
    i_ready = 1;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1; i_a = $urandom; i_b = $urandom; i_signed_en = 1'($urandom); i_tag = TW'(c + 1);
      cycle();
    end
    i_valid = 0;
    rst = 1;
    cycle();
    rst = 0;
    check_idle("midreset_state");
    repeat (5) cycle();
    run_one(32'h0000_00FF, 32'h0000_0100, 0, 4'd15, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
`ifdef PRIM_CMP_MINMAX_EN
    test_minmax();
`endif
    test_back_to_back();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prim_cmp_pipe.md
Name: prim_cmp_pipe

Overview:
- Parametrised, pipelined magnitude comparator; successor to the fixed 16-bit combinational less-than primitive.
- Compares two WIDTH-bit operands, signed or unsigned per transaction, and reports lt/eq/gt.
- Uses a registered tree of 4-bit magnitude compares with valid/ready flow control and a sideband tag.
- Serves branch-compare and SLT/SLTU paths at widths where a single-cycle tree misses timing.

Parameters:
- WIDTH, 32, operand width; multiple of 4, minimum 8, WIDTH/4 a power of two.
- TAG_W, 4, sideband tag width carried unchanged alongside each result.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  input transaction valid
- o_ready  out  1  block accepts input this cycle
- i_a  in  WIDTH  operand A
- i_b  in  WIDTH  operand B
- i_signed_en  in  1  1 = two's-complement compare, 0 = unsigned
- i_tag  in  TAG_W  sideband tag
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_lt  out  1  A < B
- o_eq  out  1  A == B
- o_gt  out  1  A > B
- o_tag  out  TAG_W  tag of this result

Behaviour:
- LVL = log2(WIDTH/4). Pipeline has S = LVL+1 register stages.
  - Stage 0 registers the per-nibble eq/lt vectors, the MSBs of A and B, signed_en and tag.
  - Each stage k = 1..LVL registers one merge level: eq = eq_hi & eq_lo; lt = lt_hi | (eq_hi & lt_lo).
- Latency: a result appears on o_valid exactly S cycles after acceptance when no stall occurs. WIDTH=32 gives S=4.
- Throughput: 1 transaction per cycle sustained.
- Per-stage valid vld_k. ready_k = ~vld_k | ready_{k+1}; ready_S = i_ready. o_ready = ready_0.
  - Bubbles compress under stall; a stalled stage holds its data.
- Transfer occurs when valid & ready are both high on a rising edge. Data must not change while o_valid=1 & i_ready=0.
- Final result:
  - Unsigned: lt = tree lt.
  - Signed:
    - A_msb=1, B_msb=0 → lt=1.
    - A_msb=0, B_msb=1 → lt=0.
    - Same sign → tree lt.
  - eq = tree eq, independent of mode.
  - gt = ~lt & ~eq.
  - Exactly one of lt/eq/gt is 1 whenever o_valid=1.
- Outputs are registered, with no combinational path from i_a/i_b to o_*. The only combinational path is i_ready → o_ready.
- When o_valid=0, o_lt/o_eq/o_gt/o_tag hold their last value; they are driven 0 after reset.
- Reset: all vld_k=0, o_valid=0, o_lt=o_eq=o_gt=0, o_tag=0. o_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight transactions are dropped silently, with no partial output.
- Simultaneous input accept and output pop with a full pipe: both occur in the same cycle, with no bubble inserted.

Optional Feature:
- Macro PRIM_CMP_MINMAX_EN.
- When defined:
  - Adds outputs o_min and o_max (WIDTH each).
  - Operands are carried through all stages.
  - o_min = lt ? A : B; o_max = lt ? B : A, respecting i_signed_en. Equal operands give A on both.
  - Same latency and handshake; both outputs reset to 0.
- When undefined: the ports are absent and no operand registers are inferred beyond stage 0.

Decomposition:
- Package prim_cmp_pkg:
  - typedef cmp_node_t (packed struct: eq, lt).
  - Function cmp_merge(hi, lo).
  - Localparam helper computing LVL from WIDTH.
- Leaf compare reuses the existing prim_cmp_mag_4bit.
- One new sub-module: prim_cmp_pipe_stage. It is a generic registered stage with vld/ready logic, parametrised by payload width, and is instantiated S times.

Test Plan:
- WIDTH=32, unsigned, A=0x0000_0001, B=0x8000_0000, i_ready=1 → after 4 cycles o_lt=1, o_eq=0, o_gt=0, tag preserved.
- Same operands, signed → o_lt=0, o_gt=1. Then A=0xFFFF_FFFF, B=0x0000_0000 signed → o_lt=1; same pair unsigned → o_gt=1.
- A=B=0x1234_5678 in both modes → o_eq=1 only. A=0x1234_5679, B=0x1234_5678 → o_gt=1 (differs in the lowest nibble only).
- Back-to-back stream of 8 transactions with tags 0..7, i_ready held low for cycles 3–6:
  - The pipe fills and o_ready deasserts after 4 held entries.
  - All 8 results emerge in tag order with no loss or duplication.
  - Outputs stay stable while stalled.
- Assert i_rst with 3 transactions in flight → next cycle o_valid=0, all outputs 0, o_ready=1. A new transaction after reset returns with latency 4.
- PRIM_CMP_MINMAX_EN defined, signed, A=0xFFFF_FFF0 (−16), B=0x0000_0010 → o_min=0xFFFF_FFF0, o_max=0x0000_0010. Same pair unsigned → values swapped.
